// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that time-shares one sequential shift-add multiplier
// among R requesters and returns each product tagged with its requester index.
module mul_share_arbiter #(
  parameter int N   = 4,
  parameter int R   = 4,
  parameter int IW  = $clog2(R),
  parameter int TMO = 4 * N + 8
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic [R-1:0]     req,
  input  logic [R*N-1:0]   req_a,
  input  logic [R*N-1:0]   req_b,
  output logic [R-1:0]     req_ack,
  output logic             res_valid,
  output logic [IW-1:0]    res_id,
  output logic [2*N-1:0]   res_product,
  output logic             busy,
  output logic             err,
  output logic             mul_start,
  output logic [N-1:0]     mul_multiplicand,
  output logic [N-1:0]     mul_multiplier,
  input  logic             mul_ready,
  input  logic [2*N-1:0]   mul_product
);

  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rrPtr_q, rrPtr_d;
  logic [IW-1:0]   winIdx_q, winIdx_d;
  logic [R-1:0]    ack_q, ack_d;
  logic            resValid_q, resValid_d;
  logic [IW-1:0]   resId_q, resId_d;
  logic [2*N-1:0]  resProduct_q, resProduct_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic            start_q, start_d;
  logic [N-1:0]    opA_q, opA_d;
  logic [N-1:0]    opB_q, opB_d;
  logic [CW-1:0]   wdCount_q, wdCount_d;

  logic [N-1:0]    aArr [R];
  logic [N-1:0]    bArr [R];
  logic            found;
  logic [IW-1:0]   winner;
  logic [IW:0]     scanIdx;
  logic [IW:0]     winPlus;
  logic [IW-1:0]   nextPtr;
  logic            timedOut;

  for (genvar g = 0; g < R; g++) begin : g_unpack
    assign aArr[g] = req_a[g*N +: N];
    assign bArr[g] = req_b[g*N +: N];
  end

  // Rotating-priority scan: first pending request at or above rrPtr, wrapping.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    scanIdx = '0;
    for (int k = 0; k < R; k++) begin
      scanIdx = {1'b0, rrPtr_q} + (IW+1)'(k);
      if (scanIdx >= (IW+1)'(R)) scanIdx = scanIdx - (IW+1)'(R);
      if (!found && req[scanIdx[IW-1:0]]) begin
        found  = 1'b1;
        winner = scanIdx[IW-1:0];
      end
    end
    winPlus = {1'b0, winner} + 1'b1;
    nextPtr = (winPlus >= (IW+1)'(R)) ? '0 : winPlus[IW-1:0];
  end

  assign timedOut = (wdCount_q == CW'(TMO - 1));

  always_comb begin
    state_d      = state_q;
    rrPtr_d      = rrPtr_q;
    winIdx_d     = winIdx_q;
    ack_d        = '0;
    resValid_d   = 1'b0;
    resId_d      = resId_q;
    resProduct_d = resProduct_q;
    err_d        = err_q;
    start_d      = 1'b0;
    opA_d        = opA_q;
    opB_d        = opB_q;
    wdCount_d    = wdCount_q;
    case (state_q)
      IDLE: begin
        if (found && mul_ready) begin
          winIdx_d        = winner;
          opA_d           = aArr[winner];
          opB_d           = bArr[winner];
          rrPtr_d         = nextPtr;
          ack_d[winner]   = 1'b1;
          start_d         = 1'b1;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        wdCount_d = '0;
        state_d   = WAIT_BUSY;
      end
      // The multiplier still reports ready in the cycle after start, so wait for it to drop.
      WAIT_BUSY: begin
        wdCount_d = wdCount_q + 1'b1;
        if (timedOut) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (!mul_ready) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        wdCount_d = wdCount_q + 1'b1;
        if (timedOut) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (mul_ready) begin
          resProduct_d = mul_product;
          resId_d      = winIdx_q;
          resValid_d   = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      rrPtr_q      <= '0;
      winIdx_q     <= '0;
      ack_q        <= '0;
      resValid_q   <= 1'b0;
      resId_q      <= '0;
      resProduct_q <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      start_q      <= 1'b0;
      opA_q        <= '0;
      opB_q        <= '0;
      wdCount_q    <= '0;
    end else begin
      state_q      <= state_d;
      rrPtr_q      <= rrPtr_d;
      winIdx_q     <= winIdx_d;
      ack_q        <= ack_d;
      resValid_q   <= resValid_d;
      resId_q      <= resId_d;
      resProduct_q <= resProduct_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      start_q      <= start_d;
      opA_q        <= opA_d;
      opB_q        <= opB_d;
      wdCount_q    <= wdCount_d;
    end
  end

  assign req_ack          = ack_q;
  assign res_valid        = resValid_q;
  assign res_id           = resId_q;
  assign res_product      = resProduct_q;
  assign busy             = busy_q;
  assign err              = err_q;
  assign mul_start        = start_q;
  assign mul_multiplicand = opA_q;
  assign mul_multiplier   = opB_q;

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter and sequencer that shares one N-bit shift-add sequential multiplier among R requesters. It accepts operand pairs from requesters, issues each to the multiplier with a one-cycle start pulse, and tracks the multiplier's ready handshake through load and shift-add. It then returns the 2N-bit product tagged with the requester index. It sits between the requesting datapath units and the single multiplier instance.

## Interface
- N, default 4: operand width; the multiplier's product is 2N bits.
- R, default 4: number of requesters (≥2).
- IW, default $clog2(R): requester index width.
- TMO, default 4*N+8: watchdog limit in cycles for any multiplier wait state.

Ports:
- clock  in  1  Rising-edge clock.
- Reset  in  1  Reset, synchronous, active-high.
- req  in  R  Per-requester request level; held until the matching ack.
- req_a  in  R*N  Multiplicands; slice i = [i*N +: N]; stable while req[i]=1.
- req_b  in  R*N  Multipliers; same slicing.
- req_ack  out  R  One-hot, one-cycle pulse: request accepted.
- res_valid  out  1  One-cycle pulse: result available.
- res_id  out  IW  Requester index of the result.
- res_product  out  2N  Product {A,Q}; held until the next result.
- busy  out  1  High in every state except IDLE.
- err  out  1  Sticky watchdog flag; cleared only by Reset.
- mul_start  out  1  Start pulse to the multiplier.
- mul_multiplicand  out  N  Latched operand a.
- mul_multiplier  out  N  Latched operand b.
- mul_ready  in  1  Multiplier ready; high when idle.
- mul_product  in  2N  Multiplier product.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- **IDLE:**
  - Condition: |req and mul_ready=1.
  - Winner: first set bit of req scanning upward from rr_ptr, wrapping R-1→0.
  - Actions: latch winner index and operands; go to ISSUE; set rr_ptr to winner+1 mod R.
  - If mul_ready=0, the arbiter waits in IDLE.
- **ISSUE (one cycle):**
  - mul_start=1; req_ack[winner]=1.
  - Go to WAIT_BUSY.
- **WAIT_BUSY:**
  - Exit on mul_ready=0 → WAIT_DONE.
  - The multiplier still shows ready=1 in the cycle after start, so this state is required.
- **WAIT_DONE:**
  - Exit on mul_ready=1: capture mul_product into res_product, capture index into res_id, pulse res_valid next cycle, go to IDLE.
- **Watchdog:**
  - A counter clears on entry to WAIT_BUSY and increments in WAIT_BUSY and WAIT_DONE.
  - When it reaches TMO: set err=1, drop the transaction (no res_valid), go to IDLE.
- mul_multiplicand and mul_multiplier hold the latched values from ISSUE until the next grant.
- Requests: a requester must drop req the cycle after req_ack. A req still high when IDLE is next evaluated is treated as a new request.
- No result backpressure; consumers must take res_valid when it pulses.
- **Reset values:**
  - State IDLE, rr_ptr=0.
  - req_ack=0, res_valid=0, res_id=0, res_product=0.
  - busy=0, err=0, mul_start=0, operand registers 0.
- **Reset mid-operation:** abort immediately with no res_valid. The multiplier shares Reset and returns to idle with it.

## Timing
- Request sampled in IDLE at cycle T:
  - T+1: ISSUE, req_ack and mul_start high.
  - T+2: multiplier load, mul_ready=0.
  - T+3 … T+2+N: N shift-add cycles.
  - T+3+N: mul_ready=1, product captured.
  - T+4+N: res_valid=1; state is IDLE and may accept the next request in this same cycle.
- Latency request→result is N+4 cycles; sustained throughput is one product per N+4 cycles.
- busy is high T+1 … T+3+N.
- Simultaneous requests: exactly one grant per IDLE evaluation, with rotating priority. Starvation bound is (R-1) transactions.
- req arriving while busy is held until IDLE; no ack is issued early.
- All outputs are registered.

## Test plan
- Single request, N=4, R=4: req[2], a=4'd13, b=4'd11 at T → req_ack=4'b0100 at T+1; res_valid at T+8 with res_id=2, res_product=8'd143; busy low at T+8.
- Fairness: req=4'b1111 held continuously, rr_ptr=0 → grant order 0,1,2,3,0; each result 8 cycles apart with the correct res_id.
- Boundary operands: 4'hF×4'hF → 8'd225; 0×4'h9 → 0; 4'h1×4'h8 → 8'd8.
- Wrap-around: after a grant to 3, req=4'b1001 → grant 0, then 3.
- Reset at T+5 mid-transaction → no res_valid; all outputs at reset values the next cycle; a new request completes normally afterwards.
- Watchdog: model the multiplier with mul_ready stuck at 1 after start → err=1 exactly TMO cycles after entering WAIT_BUSY; no res_valid; returns to IDLE.
